// File: rtl/multi_seed_bist_ctrl.sv
// -----------------------------------------------------------------------------
// multi_seed_bist_ctrl
//
// Circular-BIST controller for an N-channel circuit-under-test. An LFSR drives
// the CUT inputs, a MISR compacts the CUT responses, and the final signature is
// checked against a golden value. The controller can also sweep seeds in
// hardware, from the supplied seed up to the all-ones seed, while accumulating
// a single signature across every session.
//
// Ports
//   clock_i          sole clock, rising edge
//   reset_i          asynchronous, active-high; clears all state
//   bist_start_i     start pulse, accepted in IDLE or DONE
//   bist_abort_i     return to IDLE next cycle (has priority over start)
//   sweep_mode_i     sampled with start; 1 = sweep seeds up to all-ones
//   lfsr_seed_i      start seed, sampled with start (0 runs as 1)
//   golden_sig_i     expected signature, sampled in COMPARE
//   cut_rsp_i        CUT response
//   pattern_o        LFSR low bits while in RUN, else 0
//   test_mode_o      high in every state except IDLE
//   cut_reset_o      high during CUT_RST
//   signature_out_o  live MISR contents
//   session_idx_o    seed of the current session
//   bist_end_o       high in DONE
//   pass_fail_o      1 = signature matched; valid while bist_end_o
// -----------------------------------------------------------------------------
module multi_seed_bist_ctrl #(
  parameter int                PAT_W     = 4,
  parameter int                RSP_W     = 8,
  parameter int                LFSR_W    = 5,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 5'b10100,
  parameter logic [RSP_W-1:0]  MISR_TAPS = 8'b10111000,
  parameter int                TEST_LEN  = 255,
  parameter int                RSP_LAT   = 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              bist_start_i,
  input  logic              bist_abort_i,
  input  logic              sweep_mode_i,
  input  logic [LFSR_W-1:0] lfsr_seed_i,
  input  logic [RSP_W-1:0]  golden_sig_i,
  input  logic [RSP_W-1:0]  cut_rsp_i,
  output logic [PAT_W-1:0]  pattern_o,
  output logic              test_mode_o,
  output logic              cut_reset_o,
  output logic [RSP_W-1:0]  signature_out_o,
  output logic [LFSR_W-1:0] session_idx_o,
  output logic              bist_end_o,
  output logic              pass_fail_o
);

  // Counter covers RUN (0..TEST_LEN-1), FLUSH (0..RSP_LAT-1) and CUT_RST (0..1).
  localparam int              CNT_W   = $clog2(TEST_LEN + 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TEST_LEN - 1);
  localparam logic [CNT_W-1:0] LAT_C    = CNT_W'(RSP_LAT);
  localparam logic [CNT_W-1:0] FL_LAST  = CNT_W'(RSP_LAT - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CUT_RST = 3'd1,
    ST_RUN     = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [RSP_W-1:0]    misr_q;
  logic                sweep_q;
  logic [LFSR_W-1:0]   session_q;
  logic [PAT_W-1:0]    pattern_q;
  logic                test_mode_q;
  logic                cut_reset_q;
  logic                bist_end_q;
  logic                pass_fail_q;

  logic [LFSR_W-1:0]   lfsr_d;
  logic [RSP_W-1:0]    misr_d;
  logic [LFSR_W-1:0]   seed_d;
  logic                sess_end_d;
  logic                sess_more_d;

  // LFSR feedback bit: parity of the tapped positions.
  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] v);
    return ^(v & LFSR_TAPS);
  endfunction

  // MISR feedback bit: parity of the tapped positions.
  function automatic logic misr_fb(input logic [RSP_W-1:0] v);
    return ^(v & MISR_TAPS);
  endfunction

  // Next LFSR/MISR values, seed sanitising and end-of-session detection.
  always_comb begin
    lfsr_d      = {lfsr_q[LFSR_W-2:0], lfsr_fb(lfsr_q)};
    misr_d      = {misr_q[RSP_W-2:0], misr_fb(misr_q)} ^ cut_rsp_i;
    sess_more_d = sweep_q & ~(&session_q);
    // An all-zero seed would lock the LFSR up, so it runs as seed 1.
    if (lfsr_seed_i == {LFSR_W{1'b0}}) begin
      seed_d = {{(LFSR_W-1){1'b0}}, 1'b1};
    end else begin
      seed_d = lfsr_seed_i;
    end
    // With zero latency there is no FLUSH: the session ends on the last RUN cycle.
    if ((RSP_LAT == 0) && (state_q == ST_RUN) && (cnt_q == RUN_LAST)) begin
      sess_end_d = 1'b1;
    end else if ((state_q == ST_FLUSH) && (cnt_q == FL_LAST)) begin
      sess_end_d = 1'b1;
    end else begin
      sess_end_d = 1'b0;
    end
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      lfsr_q      <= {LFSR_W{1'b0}};
      misr_q      <= {RSP_W{1'b0}};
      sweep_q     <= 1'b0;
      session_q   <= {LFSR_W{1'b0}};
      pattern_q   <= {PAT_W{1'b0}};
      test_mode_q <= 1'b0;
      cut_reset_q <= 1'b0;
      bist_end_q  <= 1'b0;
      pass_fail_q <= 1'b0;
    end else if (bist_abort_i) begin
      // Abort keeps the MISR so the partial signature stays observable.
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      pattern_q   <= {PAT_W{1'b0}};
      test_mode_q <= 1'b0;
      cut_reset_q <= 1'b0;
      bist_end_q  <= 1'b0;
      pass_fail_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bist_start_i) begin
            state_q     <= ST_CUT_RST;
            cnt_q       <= {CNT_W{1'b0}};
            lfsr_q      <= seed_d;
            session_q   <= seed_d;
            sweep_q     <= sweep_mode_i;
            misr_q      <= {RSP_W{1'b0}};
            test_mode_q <= 1'b1;
            cut_reset_q <= 1'b1;
            bist_end_q  <= 1'b0;
            pass_fail_q <= 1'b0;
          end
        end
        ST_CUT_RST: begin
          if (cnt_q == RST_LAST) begin
            state_q     <= ST_RUN;
            cnt_q       <= {CNT_W{1'b0}};
            cut_reset_q <= 1'b0;
            pattern_q   <= lfsr_q[PAT_W-1:0];
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          lfsr_q <= lfsr_d;
          // The first RSP_LAT responses belong to the CUT-reset period.
          if (cnt_q >= LAT_C) begin
            misr_q <= misr_d;
          end
          if (cnt_q == RUN_LAST) begin
            state_q   <= ST_FLUSH;
            cnt_q     <= {CNT_W{1'b0}};
            pattern_q <= {PAT_W{1'b0}};
          end else begin
            cnt_q     <= cnt_q + CNT_W'(1);
            pattern_q <= lfsr_d[PAT_W-1:0];
          end
        end
        ST_FLUSH: begin
          misr_q <= misr_d;
          cnt_q  <= cnt_q + CNT_W'(1);
        end
        ST_COMPARE: begin
          state_q     <= ST_DONE;
          pass_fail_q <= (misr_q == golden_sig_i);
          bist_end_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
      // End of session overrides the per-state next values above (later
      // non-blocking assignments win): either start the next sweep seed or
      // move on to COMPARE.
      if (sess_end_d) begin
        cnt_q <= {CNT_W{1'b0}};
        if (sess_more_d) begin
          state_q     <= ST_CUT_RST;
          session_q   <= session_q + LFSR_W'(1);
          lfsr_q      <= session_q + LFSR_W'(1);
          cut_reset_q <= 1'b1;
        end else begin
          state_q <= ST_COMPARE;
        end
      end
    end
  end

  assign pattern_o       = pattern_q;
  assign test_mode_o     = test_mode_q;
  assign cut_reset_o     = cut_reset_q;
  assign signature_out_o = misr_q;
  assign session_idx_o   = session_q;
  assign bist_end_o      = bist_end_q;
  assign pass_fail_o     = pass_fail_q;

endmodule

// File: doc/multi_seed_bist_ctrl.md
# multi_seed_bist_ctrl

Parametrised circular-BIST controller that drives an N-channel circuit-under-test (CUT, e.g. the request arbiter) with LFSR patterns and compacts its responses in a MISR. It then compares the final signature against a golden value. Compared with the fixed single-seed controller, it adds configurable widths, test length and response latency. It also adds an in-hardware seed-sweep mode, zero-seed protection, and abort. It sits between the top-level test port and the CUT.

## Interface
- PAT_W, 4: pattern width, equal to the CUT input channel count.
- RSP_W, 8: CUT response width, equal to the MISR and signature width.
- LFSR_W, 5: LFSR width; must be ≥ PAT_W.
- LFSR_TAPS, 5'b10100: feedback mask (x^5+x^3+1).
- MISR_TAPS, 8'b10111000: feedback mask (x^8+x^6+x^5+x^4+1).
- TEST_LEN, 255: patterns applied per session (≥ 1).
- RSP_LAT, 1: CUT pattern-to-response latency in cycles (0..TEST_LEN).
- Ports:
  - clock  in  1  sole clock; all logic on its rising edge.
  - reset  in  1  asynchronous, active-high; clears all state.
  - bist_start  in  1  pulse; starts a run from IDLE or DONE.
  - bist_abort  in  1  returns to IDLE from any state next cycle.
  - sweep_mode  in  1  sampled with bist_start; 1 sweeps seeds.
  - lfsr_seed  in  LFSR_W  start seed, sampled with bist_start.
  - golden_sig  in  RSP_W  expected signature, sampled in COMPARE.
  - cut_rsp  in  RSP_W  CUT response.
  - pattern  out  PAT_W  equals lfsr[PAT_W-1:0] in RUN, else 0.
  - test_mode  out  1  high in every state except IDLE.
  - cut_reset  out  1  high in CUT_RST.
  - signature_out  out  RSP_W  live MISR contents.
  - session_idx  out  LFSR_W  seed of the current session.
  - bist_end  out  1  high in DONE.
  - pass_fail  out  1  1 = signature matched, valid while bist_end.

## Operation
- Reset values: all outputs 0, state IDLE, LFSR 0, MISR 0.
- States and transitions:
  - IDLE: on bist_start, load LFSR from lfsr_seed. An all-zero seed loads 1. Latch sweep_mode, clear MISR, go to CUT_RST.
  - CUT_RST: lasts exactly 2 cycles with cut_reset=1, then RUN.
  - RUN: lasts TEST_LEN cycles. The LFSR advances every cycle: lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)}. Then FLUSH, or skip to end-of-session when RSP_LAT=0.
  - FLUSH: lasts RSP_LAT cycles; pattern=0.
  - End of session:
    - Sweep mode with session_idx not all-ones: increment session_idx, load it into the LFSR, go to CUT_RST. The MISR is not cleared.
    - Otherwise: go to COMPARE.
  - COMPARE: 1 cycle; registers pass_fail = (MISR == golden_sig).
  - DONE: bist_end=1; pass_fail and signature are held. bist_start restarts the sequence as from IDLE.
- MISR compaction:
  - Update rule: misr <= {misr[RSP_W-2:0], ^(misr & MISR_TAPS)} ^ cut_rsp.
  - Updates on RUN cycles with index ≥ RSP_LAT (index counts from 0) and on every FLUSH cycle. That is exactly TEST_LEN updates per session.
  - Holds in all other states.
- Sweep sessions: lfsr_seed .. 2^LFSR_W-1 inclusive. Seed 0 runs as seed 1.
- bist_start in CUT_RST/RUN/FLUSH/COMPARE is ignored.
- bist_abort has priority over bist_start. It clears bist_end and pass_fail and returns to IDLE. The MISR value is retained on signature_out.
- reset mid-run: state returns to IDLE and all outputs drop to 0 asynchronously.

## Timing
- Cycle 0 = bist_start sampled high in IDLE.
  - Cycles 1–2: CUT_RST.
  - Cycles 3..TEST_LEN+2: RUN.
  - Then RSP_LAT FLUSH cycles.
  - Then COMPARE, with DONE/bist_end on the following cycle.
- Single-run total: bist_end rises TEST_LEN+RSP_LAT+4 cycles after bist_start.
- Sweep total: S×(TEST_LEN+RSP_LAT+2)+2 cycles to bist_end, where S is the session count.
- The pattern changes on the clock edge after each LFSR update. The CUT must present the response for pattern k exactly RSP_LAT cycles later.
- Counters are sized as clog2(TEST_LEN+1). They wrap nowhere: terminal counts are compared exactly.

## Test plan
- Pattern sequence: seed 5'b00001, TEST_LEN=4, sweep 0, cut_rsp held 0 → pattern 1,2,4,9 on RUN cycles. Signature 0, pass_fail=1 with golden 0. bist_end at cycle 9.
- Compaction: bench CUT model rsp = registered {pattern, ~pattern}, RSP_LAT=1, default parameters.
  - Correct golden → pass_fail=1.
  - Flip one bit of golden → pass_fail=0.
  - Force one response bit stuck-at-1 → pass_fail=0.
- Zero seed: lfsr_seed=0 → pattern sequence and signature identical to the seed-1 run.
- Sweep: seed 5'd30, sweep 1 → two sessions with session_idx 30 then 31 and two CUT_RST pulses. bist_end after 2×(TEST_LEN+RSP_LAT+2)+2 cycles. Signature differs from the single seed-30 run.
- Abort and reset:
  - bist_abort mid-RUN → IDLE next cycle; test_mode, bist_end and pass_fail=0.
  - bist_start during RUN is ignored.
  - Async reset mid-FLUSH clears all outputs without a clock edge.
- Restart from DONE: bist_start in DONE → bist_end falls next cycle and a fresh run yields the identical signature.
